uart_rx: RTL

- UART receiver. Deserializes the asynchronous serial line into DATA_BITS-wide words.
- Sits directly upstream of the interface block: its o_rx_done / o_rx_data drive the interface's i_rx_done / i_rx_data_in.
- Sampling is timed by an external 16x-oversampling baud tick from the baud-rate generator.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). No parity in the base build.

---
 rtl/uart_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (1 start, DATA_BITS data LSB first, 1 stop).
// Optional even-parity bit and o_parity_err port when UART_RX_PARITY_EN is defined.
// Counters only advance on i_tick; all decisions use the synchronized line rx_s.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_rx_data,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_frame_err
);

    // Tick counter must cover both the 16-tick bit period and the stop span.
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_BREAK  = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [S_W-1:0]         s_reg, s_next;
    logic [N_W-1:0]         n_reg, n_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   done_reg, done_next;
    logic                   ferr_reg, ferr_next;
    logic                   rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_reg, par_next;
    logic                   perr_reg, perr_next;
    logic                   parity_ok;
    // Even parity: the received parity bit must equal the XOR of the data bits.
    assign parity_ok = (^shift_reg) == par_reg;
`endif

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers, including the registered output pulses.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state and counter logic; everything except the IDLE exit waits for a tick.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shift_next = shift_reg;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_reg == S_W'(7)) begin
                        s_next = '0;
                        n_next = '0;
                        // Line back high at mid start bit means it was a glitch.
                        state_next = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (n_reg == N_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        par_next   = rx_s;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_tick) begin
                    if (s_reg == S_W'(SB_TICK - 1)) begin
                        s_next     = '0;
                        // A low stop bit parks in BREAK until the line idles again.
                        state_next = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: done / frame / parity pulses are mutually exclusive by construction.
    always_comb begin
        done_next = 1'b0;
        ferr_next = 1'b0;
        data_next = data_reg;
`ifdef UART_RX_PARITY_EN
        perr_next = 1'b0;
`endif
        if (state_reg == ST_STOP && i_tick && s_reg == S_W'(SB_TICK - 1)) begin
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                if (parity_ok) begin
                    done_next = 1'b1;
                    data_next = shift_reg;
                end else begin
                    perr_next = 1'b1;
                end
`else
                done_next = 1'b1;
                data_next = shift_reg;
`endif
            end else begin
                ferr_next = 1'b1;
            end
        end
    end

    assign o_rx_done   = done_reg;
    assign o_rx_data   = data_reg;
    assign o_frame_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_reg;
`endif

endmodule
